fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset; bits [1:0] SHALL be 0.
REQ-002 Parameter ADDR_WIDTH, default 16, byte-address width of instruction memory; PC arithmetic wraps modulo 2^ADDR_WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low, sampled on rising clk edge.
REQ-005 freeze  input  1  hazard stall from decode; hold PC and IF/ID register.
REQ-006 branch_taken  input  1  redirect request from execute stage.
REQ-007 branch_addr  input  32  redirect target byte address.
REQ-008 imem_pc  output  32  fetch address driven to instruction memory.
REQ-009 imem_instruction  input  32  instruction returned combinationally for imem_pc in the same cycle.
REQ-010 if_pc  output  32  registered PC+4 of the instruction held in IF/ID.
REQ-011 if_instruction  output  32  registered instruction word (IF/ID).
REQ-012 if_valid  output  1  IF/ID contents are a real fetched instruction.
REQ-013 fetch_state  output  2  current FSM state encoding.
REQ-014 fetch_count  output  32  number of instructions accepted into IF/ID since reset.

Function
REQ-015 imem_pc SHALL equal the PC register combinationally, zero-extended above ADDR_WIDTH, bits [1:0] always 0.
REQ-016 Per-edge priority: reset > branch_taken > freeze > advance.
REQ-017 Advance (branch_taken=0, freeze=0): PC <= (PC+4) mod 2^ADDR_WIDTH; if_pc <= PC+4 (same wrap); if_instruction <= imem_instruction; if_valid <= 1; fetch_count +1.
REQ-018 Freeze (branch_taken=0, freeze=1): PC, if_pc, if_instruction, if_valid, fetch_count SHALL hold.
REQ-019 Branch (branch_taken=1, any freeze): PC <= {branch_addr[ADDR_WIDTH-1:2],2'b00} zero-extended; if_instruction <= 0; if_pc <= 0; if_valid <= 0; fetch_count holds.
REQ-020 Misaligned branch_addr low bits SHALL be silently cleared; upper bits beyond ADDR_WIDTH ignored.
REQ-021 FSM states: RST=2'b00, RUN=2'b01, STALL=2'b10, REDIRECT=2'b11; fetch_state reflects the action taken at the most recent edge.
REQ-022 Transitions from any state: rst=0 -> RST; else branch_taken -> REDIRECT; else freeze -> STALL; else RUN.
REQ-023 In REDIRECT, if_valid SHALL be 0 (exactly one bubble per branch); a second consecutive branch_taken SHALL redirect again and stay in REDIRECT.
REQ-024 STALL following REDIRECT SHALL keep if_valid=0 (bubble held, not released).
REQ-025 PC at 2^ADDR_WIDTH-4 advancing SHALL wrap to 0; if_pc likewise reads 0.
REQ-026 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-027 No output SHALL depend combinationally on freeze, branch_taken or branch_addr.

Reset
REQ-028 While rst=0 at an edge: PC <= RESET_PC, if_pc <= 0, if_instruction <= 0, if_valid <= 0, fetch_count <= 0, fetch_state <= RST; freeze and branch_taken ignored.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL override and discard pending state in one edge.
REQ-030 First edge with rst=1 and no freeze/branch SHALL latch the instruction at RESET_PC.

Verification
REQ-031 Reset then 3 free edges, mem[0]=E3A01005, mem[4]=E3A02006, mem[8]=E0813002 -> if_pc 4,8,12; if_instruction matches in order; if_valid=1; fetch_count=3; imem_pc=12.
REQ-032 freeze=1 for 2 edges at PC=8 -> imem_pc stays 8, IF/ID unchanged, fetch_state=STALL; release -> next edge if_pc=12.
REQ-033 branch_taken=1, branch_addr=0x0000_0102, freeze=1 at PC=16 -> imem_pc=0x100, if_valid=0, fetch_state=REDIRECT, fetch_count unchanged; next free edge latches mem[0x100], if_pc=0x104.
REQ-034 PC=0xFFFC, ADDR_WIDTH=16, advance -> imem_pc=0, if_pc=0; branch_addr=0x0001_0008 -> imem_pc=8.
REQ-035 rst=0 during REDIRECT with freeze=1 -> next edge PC=RESET_PC, all outputs at reset values, fetch_state=RST.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch with a single IF/ID pipeline register.
//
// Ports
//   clk               sole clock, rising edge
//   rst               synchronous active-low reset
//   freeze            hazard stall from decode: hold PC and IF/ID
//   branch_taken      redirect request from execute
//   branch_addr       redirect target byte address
//   imem_pc           fetch address to instruction memory (PC register)
//   imem_instruction  instruction for imem_pc, returned in the same cycle
//   if_pc             PC+4 of the instruction held in IF/ID
//   if_instruction    instruction word held in IF/ID
//   if_valid          IF/ID holds a real fetched instruction
//   fetch_state       action taken at the most recent edge
//   fetch_count       instructions accepted into IF/ID since reset
//
// state       | meaning
// ------------+--------------------------------------------------
// ST_RST      | reset applied at last edge, IF/ID empty
// ST_RUN      | instruction latched into IF/ID, PC advanced
// ST_STALL    | freeze held PC and IF/ID unchanged
// ST_REDIRECT | PC loaded with branch target, IF/ID flushed
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  output logic        if_valid,
  output logic [1:0]  fetch_state,
  output logic [31:0] fetch_count
);

  // Word-aligned mask of the addressable range; ADDR_WIDTH=32 yields all ones
  // before alignment because the 33-bit span truncates to zero.
  localparam logic [32:0] ADDR_SPAN = 33'd1 << ADDR_WIDTH;
  localparam logic [31:0] ADDR_MASK = (ADDR_SPAN[31:0] - 32'd1) & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_RST      = 2'b00,
    ST_RUN      = 2'b01,
    ST_STALL    = 2'b10,
    ST_REDIRECT = 2'b11
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] branch_tgt;

  assign pc_plus4   = (pc_q + 32'd4) & ADDR_MASK;
  assign branch_tgt = branch_addr & ADDR_MASK;

  always_comb begin
    state_d = ST_RUN;
    if (!rst)              state_d = ST_RST;
    else if (branch_taken) state_d = ST_REDIRECT;
    else if (freeze)       state_d = ST_STALL;
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_RST;
    else      state_q <= state_d;
  end

  // Datapath follows the action chosen for this edge; state_d already
  // encodes the reset > branch > freeze > advance priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q           <= RESET_PC & ADDR_MASK;
      if_pc          <= 32'd0;
      if_instruction <= 32'd0;
      if_valid       <= 1'b0;
      fetch_count    <= 32'd0;
    end else begin
      unique case (state_d)
        ST_REDIRECT: begin
          pc_q           <= branch_tgt;
          if_pc          <= 32'd0;
          if_instruction <= 32'd0;
          if_valid       <= 1'b0;
        end
        ST_RUN: begin
          pc_q           <= pc_plus4;
          if_pc          <= pc_plus4;
          if_instruction <= imem_instruction;
          if_valid       <= 1'b1;
          fetch_count    <= fetch_count + 32'd1;
        end
        default: begin
          // ST_STALL holds everything; a bubble stays a bubble.
        end
      endcase
    end
  end

  assign imem_pc     = pc_q;
  assign fetch_state = state_q;

endmodule
